// File: rtl/jstk_pkg.sv
// Shared types and constants for the PmodJSTK poll controller.
// Field positions describe the 40-bit PmodJSTK Data_out frame.
package jstk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_CAPTURE
  } jstk_state_t;

  localparam int          JSTK_CENTER   = 512;
  localparam logic [5:0]  JSTK_CMD_BASE = 6'b100000;

  localparam int X_LO_MSB = 39;
  localparam int X_LO_LSB = 32;
  localparam int X_HI_MSB = 25;
  localparam int X_HI_LSB = 24;
  localparam int Y_LO_MSB = 23;
  localparam int Y_LO_LSB = 16;
  localparam int Y_HI_MSB = 9;
  localparam int Y_HI_LSB = 8;
  localparam int BTN_MSB  = 2;
  localparam int BTN_LSB  = 0;

endpackage

// File: rtl/jstk_cs_sync.sv
// Two-flop synchronizer for the PmodJSTK chip select, followed by a
// registered edge detector producing one-cycle rise/fall pulses.
module jstk_cs_sync (
  input  logic clk,
  input  logic rst,
  input  logic cs,
  output logic rise,
  output logic fall
);

  logic cs_s1;
  logic cs_s2;
  logic cs_prev;

  // CS idles high, so the chain resets to 1 to avoid a spurious fall edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_prev <= 1'b1;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      cs_s1   <= cs;
      cs_s2   <= cs_s1;
      cs_prev <= cs_s2;
      rise    <= cs_s2 & ~cs_prev;
      fall    <= ~cs_s2 & cs_prev;
    end
  end

endmodule

// File: rtl/jstk_poll_ctrl.sv
// Periodic PmodJSTK poll scheduler: starts transfers at a fixed rate, watches
// the synchronized CS for completion, and decodes the frame for game logic.
module jstk_poll_ctrl
  import jstk_pkg::*;
#(
  parameter int POLL_CYCLES    = 1_000_000,
  parameter int TIMEOUT_CYCLES = 200_000,
  parameter int DEADZONE       = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  led_in,
  input  logic        clear_err,
  input  logic        jstk_cs,
  input  logic [39:0] jstk_data,
  output logic        jstk_mode,
  output logic [7:0]  jstk_cmd,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic [2:0]  btn,
  output logic        left,
  output logic        right,
  output logic        up,
  output logic        down,
  output logic        sample_valid,
  output logic        timeout_err,
  output logic        busy
);

  localparam int PW = $clog2(POLL_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [10:0]   LO_LIM    = 11'(JSTK_CENTER - DEADZONE);
  localparam logic [10:0]   HI_LIM    = 11'(JSTK_CENTER + DEADZONE);

  jstk_state_t   state;
  jstk_state_t   next_state;
  logic [PW-1:0] poll_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          cs_rise;
  logic          cs_fall;
  logic          poll_hit;
  logic          tmo_hit;
  logic          timeout_set;
  logic          capture_en;
  logic [9:0]    x_new;
  logic [9:0]    y_new;
  logic          unused_frame_bits;

  jstk_cs_sync u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .cs   (jstk_cs),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  assign x_new = {jstk_data[X_HI_MSB:X_HI_LSB], jstk_data[X_LO_MSB:X_LO_LSB]};
  assign y_new = {jstk_data[Y_HI_MSB:Y_HI_LSB], jstk_data[Y_LO_MSB:Y_LO_LSB]};
  assign unused_frame_bits = ^{jstk_data[31:26], jstk_data[15:10], jstk_data[7:3]};

  assign poll_hit = (poll_cnt == POLL_LAST);
  assign tmo_hit  = (tmo_cnt == TMO_LAST);

  always_comb begin
    next_state  = state;
    timeout_set = 1'b0;
    capture_en  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && poll_hit) next_state = ST_REQ;
      end
      ST_REQ: begin
        if (cs_fall) begin
          next_state = ST_XFER;
        end else if (tmo_hit) begin
          next_state  = ST_IDLE;
          timeout_set = 1'b1;
        end
      end
      ST_XFER: begin
        // A completed frame beats a timeout landing on the same cycle.
        if (cs_rise) begin
          next_state = ST_CAPTURE;
          capture_en = 1'b1;
        end else if (tmo_hit) begin
          next_state  = ST_IDLE;
          timeout_set = 1'b1;
        end
      end
      ST_CAPTURE: next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      poll_cnt     <= '0;
      tmo_cnt      <= '0;
      jstk_mode    <= 1'b0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      state        <= next_state;
      jstk_mode    <= (next_state == ST_REQ);
      busy         <= (next_state != ST_IDLE);
      sample_valid <= (next_state == ST_CAPTURE);
      if (state == ST_IDLE && enable) begin
        poll_cnt <= poll_hit ? '0 : poll_cnt + PW'(1);
      end
      if (next_state != state) begin
        tmo_cnt <= '0;
      end else if (state == ST_REQ || state == ST_XFER) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
    end
  end

  // The command is frozen at REQ entry so LED changes only reach the next poll.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      jstk_cmd <= 8'h80;
    end else if (state == ST_IDLE && next_state == ST_REQ) begin
      jstk_cmd <= {JSTK_CMD_BASE, led_in};
    end
  end

  // Captured on the XFER->CAPTURE step, so the outputs line up with sample_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_pos <= 10'(JSTK_CENTER);
      y_pos <= 10'(JSTK_CENTER);
      btn   <= 3'b000;
      left  <= 1'b0;
      right <= 1'b0;
      up    <= 1'b0;
      down  <= 1'b0;
    end else if (capture_en) begin
      x_pos <= x_new;
      y_pos <= y_new;
      btn   <= jstk_data[BTN_MSB:BTN_LSB];
      left  <= ({1'b0, x_new} < LO_LIM);
      right <= ({1'b0, x_new} > HI_LIM);
      down  <= ({1'b0, y_new} < LO_LIM);
      up    <= ({1'b0, y_new} > HI_LIM);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout_err <= 1'b0;
    end else if (timeout_set) begin
      timeout_err <= 1'b1;
    end else if (clear_err) begin
      timeout_err <= 1'b0;
    end
  end

endmodule
